// File: rtl/button_pkg.sv
// Shared types and default timing for the button event decoder.
package button_pkg;

  // Default timing, sized for a 50 MHz clock.
  localparam int DEF_CNT_W         = 26;
  localparam int DEF_LONG_CYCLES   = 25_000_000;
  localparam int DEF_GAP_CYCLES    = 12_500_000;
  localparam int DEF_REPEAT_CYCLES = 5_000_000;

  // Gesture FSM states.
  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_GAP,
    SECOND_PRESS
  } state_t;

  // One-cycle event pulses produced by the FSM.
  typedef struct packed {
    logic press;
    logic release_evt;
    logic short_press;
    logic long_press;
    logic double_click;
    logic repeat_evt;
  } pulses_t;

endpackage

// File: rtl/button_event_decoder_if.sv
// Button level in, gesture events out. The release and repeat events carry an
// _evt suffix because "release" and "repeat" are reserved words.
interface button_event_decoder_if;
  logic db_in;
  logic en;
  logic press;
  logic release_evt;
  logic short_press;
  logic long_press;
  logic double_click;
  logic repeat_evt;
  logic held;

  // Side that drives the button level and consumes the events.
  modport master (
    output db_in, en,
    input  press, release_evt, short_press, long_press, double_click, repeat_evt, held
  );

  // The decoder itself.
  modport slave (
    input  db_in, en,
    output press, release_evt, short_press, long_press, double_click, repeat_evt, held
  );
endinterface

// File: rtl/level_edge_detect.sv
// Registers the debounced level and produces accepted rise/fall strobes.
// Edges only count once the button has been seen released (armed), so a button
// held through reset or through a disable never fakes a press.
module level_edge_detect (
  input  logic clk,
  input  logic n_reset,
  input  logic db_in,
  input  logic en,
  output logic armed,
  output logic rise,
  output logic fall
);

  logic db_q;

  // Previous level and arming flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      db_q  <= 1'b0;
      armed <= 1'b0;
    end else begin
      db_q <= db_in;
      if (!en) begin
        armed <= 1'b0;
      end else if (!db_in) begin
        armed <= 1'b1;
      end
    end
  end

  assign rise = db_in & ~db_q & armed;
  assign fall = ~db_in & db_q & armed;

endmodule

// File: rtl/button_event_decoder.sv
// Decodes a debounced button level into press/release, short press, long press
// with auto-repeat, and double click. All outputs are registered: each pulse
// appears the cycle after the clock edge that sampled its cause.
module button_event_decoder
  import button_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input logic                   clk,
  input logic                   n_reset,
  button_event_decoder_if.slave bus
);

  typedef logic [CNT_W-1:0] cnt_t;

  // Terminal counts; cnt reaching one of these marks the threshold cycle.
  localparam cnt_t LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam cnt_t GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam cnt_t REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam cnt_t CNT_ONE     = CNT_W'(1);

  logic    armed;
  logic    rise;
  logic    fall;
  state_t  state;
  state_t  state_n;
  cnt_t    cnt;
  cnt_t    cnt_n;
  cnt_t    cnt_inc;
  pulses_t pulses;
  pulses_t pulses_n;
  logic    held;
  logic    held_n;

  level_edge_detect u_edge (
    .clk     (clk),
    .n_reset (n_reset),
    .db_in   (bus.db_in),
    .en      (bus.en),
    .armed   (armed),
    .rise    (rise),
    .fall    (fall)
  );

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_ONE;

  // Next state, counter and pulses; fall beats long threshold, rise beats gap timeout.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt_inc;
    pulses_n = '0;
    held_n   = bus.db_in & bus.en & armed;

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (rise) begin
          state_n        = PRESSED;
          pulses_n.press = 1'b1;
        end
      end

      PRESSED: begin
        if (fall) begin
          state_n              = WAIT_GAP;
          cnt_n                = '0;
          pulses_n.release_evt = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_n             = LONG_HELD;
          cnt_n               = '0;
          pulses_n.long_press = 1'b1;
        end
      end

      LONG_HELD: begin
        if (cnt == REPEAT_LAST) begin
          cnt_n               = '0;
          pulses_n.repeat_evt = 1'b1;
        end
        if (fall) begin
          state_n              = IDLE;
          cnt_n                = '0;
          pulses_n.release_evt = 1'b1;
        end
      end

      WAIT_GAP: begin
        if (rise) begin
          state_n               = SECOND_PRESS;
          cnt_n                 = '0;
          pulses_n.press        = 1'b1;
          pulses_n.double_click = 1'b1;
        end else if (cnt == GAP_LAST) begin
          state_n              = IDLE;
          cnt_n                = '0;
          pulses_n.short_press = 1'b1;
        end
      end

      SECOND_PRESS: begin
        if (fall) begin
          state_n              = IDLE;
          cnt_n                = '0;
          pulses_n.release_evt = 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // Disable overrides everything and parks the decoder.
    if (!bus.en) begin
      state_n  = IDLE;
      cnt_n    = '0;
      pulses_n = '0;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state  <= IDLE;
      cnt    <= '0;
      pulses <= '0;
      held   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      pulses <= pulses_n;
      held   <= held_n;
    end
  end

  assign bus.press        = pulses.press;
  assign bus.release_evt  = pulses.release_evt;
  assign bus.short_press  = pulses.short_press;
  assign bus.long_press   = pulses.long_press;
  assign bus.double_click = pulses.double_click;
  assign bus.repeat_evt   = pulses.repeat_evt;
  assign bus.held         = held;

endmodule
